// File: rtl/trigger_gen_pkg.sv
// Shared types and constants for the trigger pulse generator.
// Holds the FSM state set, counter widths and pulse-length helpers.
package trigger_gen_pkg;

  localparam int CNT_W  = 32;
  localparam int PCNT_W = 16;

  localparam logic [CNT_W-1:0] WIDTH_MIN = 32'd1;
  localparam logic [CNT_W-1:0] LOW_MIN   = 32'd1;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    HIGH,
    LOW,
    DONE
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0]  dly;
    logic [CNT_W-1:0]  wid;
    logic [CNT_W-1:0]  per;
    logic [PCNT_W-1:0] npl;
  } shadow_t;

  function automatic logic [CNT_W-1:0] eff_width(
    input logic [CNT_W-1:0] w
  );
    return (w < WIDTH_MIN) ? WIDTH_MIN : w;
  endfunction

  // Low time fills the rest of the period, never shorter than one cycle.
  function automatic logic [CNT_W-1:0] low_len(
    input logic [CNT_W-1:0] p,
    input logic [CNT_W-1:0] w
  );
    logic [CNT_W-1:0] we;
    we = eff_width(w);
    return (p > we) ? (p - we) : LOW_MIN;
  endfunction

endpackage

// File: rtl/trigger_gen_edge_det.sv
// Rise/fall detector on an already-synchronised level.
// A rise only counts after the level has been seen low once since reset.
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_d;
  logic seen_low;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_d    <= 1'b0;
      seen_low <= 1'b0;
    end else begin
      sig_d <= sig;
      if (!sig) seen_low <= 1'b1;
    end
  end

  assign rise = sig & ~sig_d & seen_low;
  assign fall = ~sig & sig_d;

endmodule

// File: rtl/trigger_gen.sv
// Programmable delayed pulse-train generator armed by a start level.
// Parameters are shadowed at arm time; a start drop aborts the train.
module trigger_gen
  import trigger_gen_pkg::*;
(
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [CNT_W-1:0]  DELAY_REG,
  input  logic [CNT_W-1:0]  WIDTH_REG,
  input  logic [CNT_W-1:0]  PERIOD_REG,
  input  logic [PCNT_W-1:0] NPULSE_REG,
  output logic              trig,
  output logic              busy,
  output logic              done
);

  logic rise;
  logic fall;

  state_e            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [PCNT_W-1:0] pcnt, pcnt_n;
  logic [PCNT_W-1:0] pcnt_inc;
  shadow_t           shd, shd_n;
  logic [CNT_W-1:0]  w_eff;
  logic [CNT_W-1:0]  l_len;

  edge_det u_edge (
    .clk   (aclk),
    .rst_n (aresetn),
    .sig   (start),
    .rise  (rise),
    .fall  (fall)
  );

  assign w_eff    = eff_width(shd.wid);
  assign l_len    = low_len(shd.per, shd.wid);
  assign pcnt_inc = pcnt + 16'd1;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      cnt   <= '0;
      pcnt  <= '0;
      shd   <= '0;
      trig  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pcnt  <= pcnt_n;
      shd   <= shd_n;
      trig  <= (state_n == HIGH);
      busy  <= (state_n != IDLE);
      done  <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pcnt_n  = pcnt;
    shd_n   = shd;
    // Abort outranks every in-state transition, including completion.
    if (fall && (state != IDLE)) begin
      state_n = IDLE;
      cnt_n   = '0;
      pcnt_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            shd_n = '{dly: DELAY_REG,
                      wid: WIDTH_REG,
                      per: PERIOD_REG,
                      npl: NPULSE_REG};
            cnt_n   = '0;
            pcnt_n  = '0;
            state_n = (DELAY_REG == '0) ? HIGH : DELAY;
          end
        end
        DELAY: begin
          if (cnt == shd.dly - 32'd1) begin
            cnt_n   = '0;
            state_n = HIGH;
          end else begin
            cnt_n = cnt + 32'd1;
          end
        end
        HIGH: begin
          if (cnt == w_eff - 32'd1) begin
            cnt_n  = '0;
            pcnt_n = pcnt_inc;
            if ((shd.npl != '0) && (pcnt_inc == shd.npl))
              state_n = DONE;
            else
              state_n = LOW;
          end else begin
            cnt_n = cnt + 32'd1;
          end
        end
        LOW: begin
          if (cnt == l_len - 32'd1) begin
            cnt_n   = '0;
            state_n = HIGH;
          end else begin
            cnt_n = cnt + 32'd1;
          end
        end
        DONE: begin
          cnt_n   = '0;
          pcnt_n  = '0;
          state_n = IDLE;
        end
        default: begin
          cnt_n   = '0;
          pcnt_n  = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_gen.sv
// Directed bench for trigger_gen with a timeline-based reference model.
// Every cycle is compared; literal checks pin key scenario timings.
module tb_trigger_gen;

  localparam int LOG_N = 1024;

  logic        aclk;
  logic        aresetn;
  logic        start;
  logic [31:0] DELAY_REG;
  logic [31:0] WIDTH_REG;
  logic [31:0] PERIOD_REG;
  logic [15:0] NPULSE_REG;
  logic        trig;
  logic        busy;
  logic        done;

  trigger_gen dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .start      (start),
    .DELAY_REG  (DELAY_REG),
    .WIDTH_REG  (WIDTH_REG),
    .PERIOD_REG (PERIOD_REG),
    .NPULSE_REG (NPULSE_REG),
    .trig       (trig),
    .busy       (busy),
    .done       (done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic tlog [LOG_N];
  logic blog [LOG_N];
  logic dlog [LOG_N];

  // Reference model: position within the train is derived from the
  // number of cycles since arming, not from any state machine.
  logic   m_prev, m_seen, m_act;
  longint m_age, m_d, m_w, m_p, m_n;
  logic   e_trig, e_busy, e_done;

  initial begin
    m_prev = 0; m_seen = 0; m_act = 0;
    m_age = 0; m_d = 0; m_w = 0; m_p = 0; m_n = 0;
    e_trig = 0; e_busy = 0; e_done = 0;
  end

  always @(posedge aclk) begin
    logic   rise, fall;
    longint we, lo, tp, o, doff;
    if (!aresetn) begin
      m_prev = 0; m_seen = 0; m_act = 0;
      e_trig = 0; e_busy = 0; e_done = 0;
    end else begin
      rise = start && !m_prev && m_seen;
      fall = !start && m_prev;
      if (m_act) begin
        if (fall) m_act = 0;
        else m_age++;
      end else if (rise) begin
        m_act = 1;
        m_age = 1;
        m_d = longint'(DELAY_REG);
        m_w = longint'(WIDTH_REG);
        m_p = longint'(PERIOD_REG);
        m_n = longint'(NPULSE_REG);
      end
      m_prev = start;
      if (!start) m_seen = 1;
      e_trig = 0; e_busy = 0; e_done = 0;
      if (m_act) begin
        we   = (m_w == 0) ? 1 : m_w;
        lo   = (m_p > we) ? m_p - we : 1;
        tp   = we + lo;
        o    = m_age - 1 - m_d;
        doff = (m_n - 1) * tp + we;
        if (m_n != 0 && o > doff) begin
          m_act = 0;
        end else begin
          e_busy = 1;
          if (m_n != 0 && o == doff) e_done = 1;
          else if (o >= 0 && (o % tp) < we) e_trig = 1;
        end
      end
    end
  end

  always @(posedge aclk) begin
    #1;
    cyc++;
    total++;
    if ({trig, busy, done} !== {e_trig, e_busy, e_done}) begin
      bad++;
      $display("FAIL cycle %0d trig/busy/done: got %b%b%b want %b%b%b",
               cyc, trig, busy, done, e_trig, e_busy, e_done);
    end
    if (cyc < LOG_N) begin
      tlog[cyc] = trig;
      blog[cyc] = busy;
      dlog[cyc] = done;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic set_regs(input int d, input int w, input int p,
                          input int n);
    DELAY_REG  = 32'(d);
    WIDTH_REG  = 32'(w);
    PERIOD_REG = 32'(p);
    NPULSE_REG = 16'(n);
  endtask

  function automatic int vec(input int b, input int n, input int sel);
    int v;
    v = 0;
    for (int i = 0; i < n; i++) begin
      logic bit_v;
      bit_v = (sel == 0) ? tlog[b+1+i] :
              (sel == 1) ? blog[b+1+i] : dlog[b+1+i];
      if (bit_v) v |= (1 << i);
    end
    return v;
  endfunction

  function automatic int cnt_rise(input int a, input int b);
    int c;
    c = 0;
    for (int i = a; i <= b; i++)
      if (tlog[i] && !tlog[i-1]) c++;
    return c;
  endfunction

  function automatic int cnt_set(input int a, input int b, input int sel);
    int c;
    c = 0;
    for (int i = a; i <= b; i++)
      if (((sel == 1) ? blog[i] : dlog[i]) == 1'b1) c++;
    return c;
  endfunction

  initial begin
    int t0, t1, td, tr;
    aresetn = 0;
    start   = 0;
    set_regs(0, 0, 0, 0);
    step(3);
    aresetn = 1;
    step(3);
    chk("reset_idle", {trig, busy, done}, 0);

    // Scenario 1: delayed finite train.
    set_regs(5, 2, 4, 3);
    step(1);
    start = 1; t0 = cyc;
    step(22);
    chk("s1_trig", vec(t0, 20, 0), 'h06660);
    chk("s1_done", vec(t0, 20, 2), 'h08000);
    chk("s1_busy", vec(t0, 20, 1), 'h0FFFF);
    start = 0;
    step(2);

    // Scenario 2: zero delay/width/period.
    set_regs(0, 0, 0, 2);
    start = 1; t0 = cyc;
    step(8);
    chk("s2_trig", vec(t0, 6, 0), 'b000101);
    chk("s2_done", vec(t0, 6, 2), 'b001000);
    start = 0;
    step(2);

    // Scenario 3: endless train aborted after ten pulses.
    set_regs(2, 1, 3, 0);
    start = 1; t0 = cyc;
    step(31);
    start = 0; td = cyc;
    step(4);
    chk("s3_pulses", cnt_rise(t0 + 1, td), 10);
    chk("s3_busy_before", int'(blog[td]), 1);
    chk("s3_trig_after", int'(tlog[td+1]), 0);
    chk("s3_busy_after", int'(blog[td+1]), 0);
    chk("s3_no_done", cnt_set(t0, td + 3, 2), 0);

    // Scenario 4: registers rewritten mid-train.
    set_regs(1, 3, 5, 2);
    start = 1; t0 = cyc;
    step(3);
    set_regs(7, 1, 9, 5);
    step(15);
    chk("s4_trig", vec(t0, 12, 0), 'h1CE);
    chk("s4_done", vec(t0, 12, 2), 'h200);
    start = 0;
    step(2);
    start = 1; t0 = cyc;
    step(50);
    chk("s4_rearm_pre", int'(tlog[t0+7]), 0);
    chk("s4_rearm_first", int'(tlog[t0+8]), 1);
    chk("s4_rearm_done", cnt_set(t0, t0 + 50, 2), 1);
    start = 0;
    step(2);

    // Scenario 5: reset during HIGH, start held high across it.
    set_regs(0, 6, 8, 0);
    start = 1; t0 = cyc;
    step(3);
    aresetn = 0; tr = cyc;
    step(1);
    aresetn = 1;
    step(10);
    chk("s5_trig_before", int'(tlog[tr]), 1);
    chk("s5_trig_after", int'(tlog[tr+1]), 0);
    chk("s5_no_rearm", cnt_set(tr + 1, tr + 10, 1), 0);
    start = 0;
    step(1);
    start = 1; t0 = cyc;
    step(3);
    chk("s5_rearm", int'(tlog[t0+1]), 1);
    start = 0;
    step(3);

    // Scenario 6: start bounce mid-train, then abort on last pulse.
    set_regs(1, 2, 4, 3);
    start = 1; t0 = cyc;
    step(4);
    start = 0;
    step(1);
    start = 1; t1 = cyc;
    step(20);
    chk("s6_done_once", cnt_set(t0, t1 + 20, 2), 1);
    start = 0;
    step(2);
    start = 1; t0 = cyc;
    step(11);
    start = 0;
    step(4);
    chk("s6_abort_trig", int'(tlog[t0+11]), 1);
    chk("s6_abort_done", int'(dlog[t0+12]), 0);
    chk("s6_abort_busy", int'(blog[t0+12]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
